// File: rtl/shifter_control_pkg.sv
//--------------------------------------------------------------------------
// Module  : shifter_control_pkg
// Brief   : Shared types and operand2 field offsets for the shifter control
//           block (shift type, controller state, bit positions).
// Rev     : 1.0  initial release
//--------------------------------------------------------------------------
`default_nettype none

package shifter_control_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_type_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RS_READ = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_HOLD    = 2'd3
    } shift_ctrl_state_t;

    // Operand2 layout: [11:8] rotate or Rs index, [11:7] shift immediate,
    // [6:5] shift type, [4] register-amount flag, [7:0] immediate byte.
    localparam int c_OP2_IMM8_LSB  = 0;
    localparam int c_OP2_ROT_LSB   = 8;
    localparam int c_OP2_RS_LSB    = 8;
    localparam int c_OP2_SHAMT_LSB = 7;
    localparam int c_OP2_TYPE_LSB  = 5;
    localparam int c_OP2_REGSH_BIT = 4;

    function automatic logic [4:0] rot_to_amount(input logic [3:0] rot);
        return {rot, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/shifter_control_if.sv
//--------------------------------------------------------------------------
// Module  : shifter_control_if
// Brief   : Link between the shifter controller and the barrel shifter.
// Rev     : 1.0  initial release
//--------------------------------------------------------------------------
`default_nettype none

interface shifter_control_if;
    import shifter_control_pkg::*;

    logic [31:0] rm;
    shift_type_t shift_type;
    logic [4:0]  shift_amount;
    logic        carry_in;
    logic [31:0] op_b;
    logic        carry_out;

    modport control_side (
        output rm, shift_type, shift_amount, carry_in,
        input  op_b, carry_out
    );

    modport shifter_side (
        input  rm, shift_type, shift_amount, carry_in,
        output op_b, carry_out
    );
endinterface

`default_nettype wire

// File: rtl/shifter_control_fixup.sv
//--------------------------------------------------------------------------
// Module  : shifter_control_fixup
// Brief   : Combinational shifter drive plus #0 / >=32 result overrides.
//           Register-amount shifts only with SHIFTER_CTRL_REGSHIFT_EN.
// Rev     : 1.0  initial release
//--------------------------------------------------------------------------
`default_nettype none

module shifter_control_fixup
    import shifter_control_pkg::*;
(
    input  logic        i_imm,
    input  logic [11:0] i_op2,
    input  logic [31:0] i_rm,
    input  logic        i_carry,
    input  logic [7:0]  i_rs_amount,
    output logic [31:0] o_sh_rm,
    output shift_type_t o_sh_type,
    output logic [4:0]  o_sh_amount,
    output logic        o_sh_carry_in,
    input  logic [31:0] i_sh_op_b,
    input  logic        i_sh_carry_out,
    output logic [31:0] o_result,
    output logic        o_carry
);

    logic [3:0]  w_rot;
    logic [4:0]  w_shamt;
    logic [7:0]  w_imm8;
    shift_type_t w_type;

    assign w_rot   = i_op2[c_OP2_ROT_LSB +: 4];
    assign w_shamt = i_op2[c_OP2_SHAMT_LSB +: 5];
    assign w_imm8  = i_op2[c_OP2_IMM8_LSB +: 8];
    assign w_type  = shift_type_t'(i_op2[c_OP2_TYPE_LSB +: 2]);

`ifndef SHIFTER_CTRL_REGSHIFT_EN
    logic w_unused_amt;
    assign w_unused_amt = ^i_rs_amount;
`endif

    always_comb begin
        o_sh_rm       = i_rm;
        o_sh_type     = w_type;
        o_sh_amount   = w_shamt;
        o_sh_carry_in = i_carry;
        o_result      = i_sh_op_b;
        o_carry       = i_sh_carry_out;

        if (i_imm) begin
            o_sh_rm = {24'd0, w_imm8};
            if (w_rot == 4'd0) begin
                o_sh_type   = SH_LSL;
                o_sh_amount = 5'd0;
            end else begin
                o_sh_type   = SH_ROR;
                o_sh_amount = rot_to_amount(w_rot);
                o_carry     = i_sh_op_b[31];
            end
        end else if (i_op2[c_OP2_REGSH_BIT]) begin
`ifdef SHIFTER_CTRL_REGSHIFT_EN
            o_sh_amount = i_rs_amount[4:0];
            // Low five bits zero would mean RRX or a full-width shift in the
            // shifter; drive a plain passthrough and fix the result below.
            if (i_rs_amount[4:0] == 5'd0) begin
                o_sh_type   = SH_LSL;
                o_sh_amount = 5'd0;
            end
            if (|i_rs_amount[7:5]) begin
                unique case (w_type)
                    SH_LSL: begin
                        o_result = 32'd0;
                        o_carry  = (i_rs_amount == 8'd32) ? i_rm[0] : 1'b0;
                    end
                    SH_LSR: begin
                        o_result = 32'd0;
                        o_carry  = (i_rs_amount == 8'd32) ? i_rm[31] : 1'b0;
                    end
                    SH_ASR: begin
                        o_result = {32{i_rm[31]}};
                        o_carry  = i_rm[31];
                    end
                    SH_ROR: begin
                        if (i_rs_amount[4:0] == 5'd0) begin
                            o_result = i_rm;
                            o_carry  = i_rm[31];
                        end
                    end
                    default: ;
                endcase
            end
`else
            o_sh_type   = SH_LSL;
            o_sh_amount = 5'd0;
`endif
        end else if (w_shamt == 5'd0) begin
            // Immediate #0 encodes LSR #32 / ASR #32; ROR #0 is RRX in the shifter.
            unique case (w_type)
                SH_LSR: begin
                    o_result = 32'd0;
                    o_carry  = i_rm[31];
                end
                SH_ASR: begin
                    o_result = {32{i_rm[31]}};
                    o_carry  = i_rm[31];
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/shifter_control.sv
//--------------------------------------------------------------------------
// Module  : shifter_control
// Brief   : Operand2 sequencer: accepts a request, optionally reads Rs, drives
//           the barrel shifter and holds the result until taken.
//           Register-amount shifts enabled by SHIFTER_CTRL_REGSHIFT_EN.
// Rev     : 1.0  initial release
//--------------------------------------------------------------------------
`default_nettype none

module shifter_control
    import shifter_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_imm,
    input  logic [11:0] req_op2,
    input  logic [31:0] req_rm,
    input  logic        req_carry,
    output logic        rs_rd_en,
    output logic [3:0]  rs_addr,
    input  logic [31:0] rs_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_op_b,
    output logic        out_carry,
    shifter_control_if.control_side shft
);

    shift_ctrl_state_t r_state;
    shift_ctrl_state_t w_next_state;

    logic        r_imm;
    logic [11:0] r_op2;
    logic [31:0] r_rm;
    logic        r_carry;
    logic [31:0] r_out_op_b;
    logic        r_out_carry;
    logic [7:0]  w_rs_amount;
    logic        w_accept;
    logic        w_reg_req;
    logic [31:0] w_sh_rm;
    shift_type_t w_sh_type;
    logic [4:0]  w_sh_amount;
    logic        w_sh_carry_in;
    logic [31:0] w_result;
    logic        w_res_carry;
    logic        w_unused;

    assign w_accept = req_valid && req_ready;
    assign rs_addr  = req_op2[c_OP2_RS_LSB +: 4];

`ifdef SHIFTER_CTRL_REGSHIFT_EN
    logic [7:0] r_rs_amount;

    assign w_reg_req = !req_imm && req_op2[c_OP2_REGSH_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_amount <= 8'd0;
        end else if (r_state == ST_RS_READ) begin
            r_rs_amount <= rs_data[7:0];
        end
    end

    assign w_rs_amount = r_rs_amount;
    assign w_unused    = ^rs_data[31:8];
`else
    assign w_reg_req   = 1'b0;
    assign w_rs_amount = 8'd0;
    assign w_unused    = ^rs_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rs_rd_en     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_reg_req) begin
                        rs_rd_en     = 1'b1;
                        w_next_state = ST_RS_READ;
                    end else begin
                        w_next_state = ST_SHIFT;
                    end
                end
            end
            ST_RS_READ: w_next_state = ST_SHIFT;
            ST_SHIFT:   w_next_state = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm       <= 1'b0;
            r_op2       <= 12'd0;
            r_rm        <= 32'd0;
            r_carry     <= 1'b0;
            r_out_op_b  <= 32'd0;
            r_out_carry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_imm   <= req_imm;
                r_op2   <= req_op2;
                r_rm    <= req_rm;
                r_carry <= req_carry;
            end
            if (r_state == ST_SHIFT) begin
                r_out_op_b  <= w_result;
                r_out_carry <= w_res_carry;
            end
        end
    end

    shifter_control_fixup u_fixup (
        .i_imm          (r_imm),
        .i_op2          (r_op2),
        .i_rm           (r_rm),
        .i_carry        (r_carry),
        .i_rs_amount    (w_rs_amount),
        .o_sh_rm        (w_sh_rm),
        .o_sh_type      (w_sh_type),
        .o_sh_amount    (w_sh_amount),
        .o_sh_carry_in  (w_sh_carry_in),
        .i_sh_op_b      (shft.op_b),
        .i_sh_carry_out (shft.carry_out),
        .o_result       (w_result),
        .o_carry        (w_res_carry)
    );

    assign shft.rm           = w_sh_rm;
    assign shft.shift_type   = w_sh_type;
    assign shft.shift_amount = w_sh_amount;
    assign shft.carry_in     = w_sh_carry_in;

    assign out_valid = (r_state == ST_HOLD);
    assign out_op_b  = r_out_op_b;
    assign out_carry = r_out_carry;

endmodule

`default_nettype wire
